// File: rtl/rd_wb_arbiter.sv
// rd_wb_arbiter: NUM_CH-way writeback arbiter (round-robin or fixed priority) that feeds
// a one-entry output register sitting in front of the register-file write port.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 5
`endif

module rd_wb_arbiter #(
   parameter int unsigned NUM_CH     = 3,
   parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 8,
   localparam int unsigned CH_W      = $clog2(NUM_CH),
   localparam int unsigned POP_W     = $clog2(NUM_CH + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mode,
   input  logic [NUM_CH-1:0]            req_valid,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] req_rd,
   input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
   output logic [NUM_CH-1:0]            req_ready,
   output logic                         wb_valid,
   input  logic                         wb_ready,
   output logic [ADDR_WIDTH-1:0]        wb_rd,
   output logic [DATA_WIDTH-1:0]        wb_data,
   output logic [CH_W-1:0]              wb_ch,
   output logic [CNT_WIDTH-1:0]         conflict_cnt
);

   logic                  r_wb_valid;
   logic [ADDR_WIDTH-1:0] r_wb_rd;
   logic [DATA_WIDTH-1:0] r_wb_data;
   logic [CH_W-1:0]       r_wb_ch;
   logic [CNT_WIDTH-1:0]  r_conflict_cnt;
   logic [CH_W-1:0]       r_rr_ptr;

   logic [CH_W-1:0]       w_base;
   logic [CH_W:0]         w_sum;
   logic [CH_W-1:0]       w_idx;
   logic                  w_found;
   logic [NUM_CH-1:0]     w_grant;
   logic [CH_W-1:0]       w_grant_idx;
   logic                  w_space;
   logic                  w_xfer;
   logic [ADDR_WIDTH-1:0] w_sel_rd;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic [POP_W-1:0]      w_pop;
   logic                  w_contended;
   logic [CH_W-1:0]       w_ptr_next;

   // Fixed priority is round-robin with the search anchored at channel 0.
   assign w_base = mode ? '0 : r_rr_ptr;

   always_comb begin
      w_sum       = '0;
      w_idx       = '0;
      w_found     = 1'b0;
      w_grant     = '0;
      w_grant_idx = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         w_sum = {1'b0, w_base} + (CH_W+1)'(k);
         if (w_sum >= (CH_W+1)'(NUM_CH)) begin
            w_sum = w_sum - (CH_W+1)'(NUM_CH);
         end
         w_idx = w_sum[CH_W-1:0];
         if (req_valid[w_idx] && !w_found) begin
            w_found        = 1'b1;
            w_grant[w_idx] = 1'b1;
            w_grant_idx    = w_idx;
         end
      end
   end

   assign w_space   = !r_wb_valid || wb_ready;
   assign req_ready = w_grant & {NUM_CH{w_space}};
   assign w_xfer    = |req_ready;

   always_comb begin
      w_sel_rd   = '0;
      w_sel_data = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         w_sel_rd   = w_sel_rd   | (req_rd[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{w_grant[i]}});
         w_sel_data = w_sel_data | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_grant[i]}});
      end
   end

   always_comb begin
      w_pop = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         w_pop = w_pop + POP_W'(req_valid[i]);
      end
   end

   assign w_contended = (w_pop >= POP_W'(2));
   assign w_ptr_next  = (w_grant_idx == CH_W'(NUM_CH - 1)) ? '0 : w_grant_idx + CH_W'(1);

   // A load in the same cycle as a drain simply overwrites the entry: no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_valid <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
         r_wb_ch    <= '0;
      end else if (w_xfer) begin
         r_wb_valid <= 1'b1;
         r_wb_rd    <= w_sel_rd;
         r_wb_data  <= w_sel_data;
         r_wb_ch    <= w_grant_idx;
      end else if (wb_ready) begin
         r_wb_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_xfer && !mode) begin
         r_rr_ptr <= w_ptr_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_conflict_cnt <= '0;
      end else if (w_xfer && w_contended && !(&r_conflict_cnt)) begin
         r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
      end
   end

   assign wb_valid     = r_wb_valid;
   assign wb_rd        = r_wb_rd;
   assign wb_data      = r_wb_data;
   assign wb_ch        = r_wb_ch;
   assign conflict_cnt = r_conflict_cnt;

`ifndef SYNTHESIS
   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (wb_valid && !wb_ready) |=> (wb_valid && $stable(wb_rd) && $stable(wb_data)
                                   && $stable(wb_ch)));
`endif

endmodule

// File: tb/tb_rd_wb_arbiter.sv
// Bench for rd_wb_arbiter: vector table, directed corner sequences and randomized traffic
// checked against a queue-free behavioural model of the arbitration rules.
module tb_rd_wb_arbiter;

   localparam int NCH = 3;
   localparam int AW  = 5;
   localparam int DW  = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              mode;
   logic [NCH-1:0]    req_valid;
   logic [NCH*AW-1:0] req_rd;
   logic [NCH*DW-1:0] req_data;
   logic [NCH-1:0]    req_ready;
   logic              wb_valid;
   logic              wb_ready;
   logic [AW-1:0]     wb_rd;
   logic [DW-1:0]     wb_data;
   logic [1:0]        wb_ch;
   logic [7:0]        conflict_cnt;

   logic              d2_mode;
   logic [NCH-1:0]    d2_valid;
   logic [NCH*AW-1:0] d2_rd;
   logic [NCH*DW-1:0] d2_data;
   logic [NCH-1:0]    d2_ready;
   logic              d2_wb_valid;
   logic              d2_wb_ready;
   logic [AW-1:0]     d2_wb_rd;
   logic [DW-1:0]     d2_wb_data;
   logic [1:0]        d2_wb_ch;
   logic [1:0]        d2_cnt;

   rd_wb_arbiter #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .req_valid(req_valid), .req_rd(req_rd),
      .req_data(req_data), .req_ready(req_ready), .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_rd(wb_rd), .wb_data(wb_data), .wb_ch(wb_ch), .conflict_cnt(conflict_cnt)
   );

   rd_wb_arbiter #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2)) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .mode(d2_mode), .req_valid(d2_valid), .req_rd(d2_rd),
      .req_data(d2_data), .req_ready(d2_ready), .wb_valid(d2_wb_valid),
      .wb_ready(d2_wb_ready), .wb_rd(d2_wb_rd), .wb_data(d2_wb_data), .wb_ch(d2_wb_ch),
      .conflict_cnt(d2_cnt)
   );

   initial forever #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Requester-side channel contents
   logic [AW-1:0] c_rd[NCH];
   logic [DW-1:0] c_data[NCH];

   task automatic pack();
      for (int i = 0; i < NCH; i++) begin
         req_rd[i*AW +: AW]   = c_rd[i];
         req_data[i*DW +: DW] = c_data[i];
      end
   endtask

   // Behavioural model state
   bit            m_valid;
   logic [AW-1:0] m_rd;
   logic [DW-1:0] m_data;
   int            m_ch;
   int            m_cnt;
   int            m_ptr;

   task automatic model_reset();
      m_valid = 0; m_rd = '0; m_data = '0; m_ch = 0; m_cnt = 0; m_ptr = 0;
   endtask

   function automatic int pick(input logic md, input logic [NCH-1:0] v, input int ptr);
      for (int k = 0; k < NCH; k++) begin
         int c;
         c = md ? k : (ptr + k) % NCH;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // Drive one cycle, check against the model at the falling edge, advance the model.
   task automatic step(input logic md, input logic [NCH-1:0] v, input logic wr, output int g);
      logic [NCH-1:0] exp_ready;
      bit             space;
      mode = md; req_valid = v; wb_ready = wr;
      pack();
      space = !m_valid || wr;
      g = space ? pick(md, v, m_ptr) : -1;
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      @(negedge clk);
      chk("req_ready", req_ready, exp_ready);
      chk("wb_valid", wb_valid, m_valid);
      chk("conflict_cnt", conflict_cnt, m_cnt);
      if (m_valid) begin
         chk("wb_ch", wb_ch, m_ch);
         chk("wb_rd", wb_rd, m_rd);
         chk("wb_data", wb_data, m_data);
      end
      @(posedge clk);
      if (g >= 0) begin
         m_valid = 1;
         m_rd    = c_rd[g];
         m_data  = c_data[g];
         m_ch    = g;
         if ($countones(v) >= 2 && m_cnt < 255) m_cnt++;
         if (!md) m_ptr = (g + 1) % NCH;
      end else if (wr) begin
         m_valid = 0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_valid = '0; wb_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      logic           md;
      logic [NCH-1:0] v;
      logic           wr;
      logic [NCH-1:0] ready;
      logic           wbv;
      logic [1:0]     ch;
      logic [7:0]     cnt;
   } vec_t;

   vec_t tbl[15];
   int   sat_exp[5];

   initial begin
      int             g;
      logic           md;
      logic [NCH-1:0] pend;

      tbl[0]  = '{1'b0, 3'b010, 1'b1, 3'b010, 1'b0, 2'd0, 8'd0};
      tbl[1]  = '{1'b0, 3'b000, 1'b1, 3'b000, 1'b1, 2'd1, 8'd0};
      tbl[2]  = '{1'b0, 3'b111, 1'b1, 3'b100, 1'b0, 2'd0, 8'd0};
      tbl[3]  = '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd2, 8'd1};
      tbl[4]  = '{1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 2'd0, 8'd2};
      tbl[5]  = '{1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 2'd1, 8'd3};
      tbl[6]  = '{1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 2'd2, 8'd4};
      tbl[7]  = '{1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 2'd2, 8'd4};
      tbl[8]  = '{1'b1, 3'b111, 1'b1, 3'b001, 1'b1, 2'd2, 8'd4};
      tbl[9]  = '{1'b1, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 8'd5};
      tbl[10] = '{1'b1, 3'b110, 1'b1, 3'b010, 1'b1, 2'd0, 8'd6};
      tbl[11] = '{1'b0, 3'b110, 1'b1, 3'b010, 1'b1, 2'd1, 8'd7};
      tbl[12] = '{1'b0, 3'b101, 1'b1, 3'b100, 1'b1, 2'd1, 8'd8};
      tbl[13] = '{1'b0, 3'b000, 1'b1, 3'b000, 1'b1, 2'd2, 8'd9};
      tbl[14] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd0, 8'd9};
      sat_exp = '{1, 2, 3, 3, 3};

      rst_n = 1'b0; mode = 1'b0; req_valid = '0; wb_ready = 1'b0;
      req_rd = '0; req_data = '0;
      d2_mode = 1'b1; d2_valid = '0; d2_wb_ready = 1'b1; d2_rd = '0; d2_data = '0;
      for (int i = 0; i < NCH; i++) begin c_rd[i] = '0; c_data[i] = '0; end
      model_reset();
      #1;
      chk("reset wb_valid", wb_valid, 1'b0);
      chk("reset wb_rd", wb_rd, '0);
      chk("reset wb_data", wb_data, '0);
      chk("reset wb_ch", wb_ch, '0);
      chk("reset conflict_cnt", conflict_cnt, '0);
      chk("reset req_ready", req_ready, '0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset with a pending entry discards it and clears the counter at once.
      c_rd[0] = 5'd5; c_data[0] = 32'hDEADBEEF;
      c_rd[1] = 5'd9; c_data[1] = 32'h1;
      step(1'b0, 3'b011, 1'b0, g);
      step(1'b0, 3'b010, 1'b0, g);
      chk("pre-reset wb_valid", wb_valid, 1'b1);
      chk("pre-reset wb_rd", wb_rd, 5'd5);
      chk("pre-reset conflict_cnt", conflict_cnt, 8'd1);
      rst_n = 1'b0; req_valid = '0;
      #1;
      chk("async reset wb_valid", wb_valid, 1'b0);
      chk("async reset conflict_cnt", conflict_cnt, '0);
      chk("async reset req_ready", req_ready, '0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      c_rd[1] = 5'd3; c_data[1] = 32'h11;
      step(1'b0, 3'b010, 1'b1, g);
      chk("post-reset wb_ch", wb_ch, 2'd1);
      chk("post-reset wb_rd", wb_rd, 5'd3);
      chk("post-reset wb_data", wb_data, 32'h11);

      // Vector table from a fresh reset
      do_reset();
      for (int i = 0; i < NCH; i++) begin c_rd[i] = AW'(10 + i); c_data[i] = DW'(32'hA0 + i); end
      pack();
      for (int r = 0; r < 15; r++) begin
         mode = tbl[r].md; req_valid = tbl[r].v; wb_ready = tbl[r].wr;
         @(negedge clk);
         chk($sformatf("tbl%0d req_ready", r), req_ready, tbl[r].ready);
         chk($sformatf("tbl%0d wb_valid", r), wb_valid, tbl[r].wbv);
         chk($sformatf("tbl%0d conflict_cnt", r), conflict_cnt, tbl[r].cnt);
         if (tbl[r].wbv) begin
            chk($sformatf("tbl%0d wb_ch", r), wb_ch, tbl[r].ch);
            chk($sformatf("tbl%0d wb_rd", r), wb_rd, 10 + tbl[r].ch);
            chk($sformatf("tbl%0d wb_data", r), wb_data, 32'hA0 + tbl[r].ch);
         end
         @(posedge clk);
         #1;
      end

      // Backpressure hold, then drain and load in the same cycle
      do_reset();
      c_rd[0] = 5'd7;  c_data[0] = 32'h77;
      c_rd[2] = 5'd12; c_data[2] = 32'h222;
      step(1'b0, 3'b001, 1'b0, g);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 3'b100, 1'b0, g);
         chk("hold wb_rd", wb_rd, 5'd7);
         chk("hold wb_data", wb_data, 32'h77);
      end
      step(1'b0, 3'b100, 1'b1, g);
      chk("no-bubble grant", g, 2);
      chk("no-bubble wb_valid", wb_valid, 1'b1);
      chk("no-bubble wb_ch", wb_ch, 2'd2);
      chk("no-bubble wb_rd", wb_rd, 5'd12);

      // Randomized traffic; requesters hold their payload until accepted
      do_reset();
      pend = '0; md = 1'b0;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NCH; i++) begin
            if (!pend[i] && $urandom_range(0, 9) < 6) begin
               pend[i]   = 1'b1;
               c_rd[i]   = AW'($urandom);
               c_data[i] = $urandom;
            end
         end
         if ($urandom_range(0, 19) == 0) md = ~md;
         step(md, pend, ($urandom_range(0, 9) < 7), g);
         if (g >= 0) pend[g] = 1'b0;
      end

      // Saturating counter on the 2-bit instance
      d2_mode = 1'b1; d2_wb_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         d2_valid = 3'b011;
         @(posedge clk);
         #1;
         chk($sformatf("sat cnt %0d", k), d2_cnt, sat_exp[k]);
      end
      d2_valid = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
